mux_nin_1out_arb: RTL and testbench
===================================

Name: mux_nin_1out_arb

Overview:
- Parametrised N-input, W-bit multiplexer with per-channel valid/ready handshakes and a registered output stage.
- Two modes: explicit select, and round-robin arbitration across requesting channels.
- Successor of the combinational 4:1 case multiplexer.
- Used wherever several producers share one downstream consumer.

Parameters:
- N, 4, number of input channels (2..16).
- W, 8, data width per channel in bits.
- SW, clog2(N) (minimum 1), width of select/index fields; derived, not overridden.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- mode  input  1  0 = select mode (sel chooses channel), 1 = round-robin mode.
- sel  input  SW  channel index used in select mode.
- in_valid  input  N  per-channel data valid.
- in_data  input  N*W  channel i occupies bits [i*W +: W].
- in_last  input  N  per-channel end-of-packet marker; used only with MUX_LOCK_EN.
- in_ready  output  N  per-channel accept; one-hot or zero.
- out_valid  output  1  output register holds a beat.
- out_data  output  W  registered data.
- out_sel  output  SW  index of the channel that supplied out_data.
- out_ready  input  1  downstream accept.

Behaviour:
- Reset: out_valid=0, out_data=0, out_sel=0, round-robin pointer rr_ptr=0, lock state cleared.
  - Reset is asynchronous; assertion mid-transfer drops any held beat.
- Output stage: load_en = ~out_valid | out_ready.
- Grant (combinational):
  - Select mode: gnt=sel, gnt_vld=in_valid[sel]. If sel>=N (non-power-of-2 N), gnt_vld=0.
  - Round-robin mode: gnt is the first i with in_valid[i]=1, searching rr_ptr, rr_ptr+1, …, N-1, 0, …, rr_ptr-1. gnt_vld=|in_valid.
- in_ready[i] = load_en & gnt_vld & (gnt==i). Only one in_ready may be high in any cycle.
- Transfer on channel i when in_valid[i] & in_ready[i]. On the next edge: out_data=in_data[i], out_sel=i, out_valid=1.
- If out_ready=1 and no transfer occurs: out_valid goes to 0, and out_data/out_sel hold their values.
- Latency: one cycle from input accept to out_valid. Throughput: one beat per cycle when out_ready is held high.
- Backpressure: with out_valid=1 and out_ready=0, all in_ready=0 and the output register holds.
- rr_ptr:
  - On each round-robin-mode transfer, rr_ptr = (gnt+1) mod N, wrapping from N-1 to 0.
  - No update in select mode or on cycles without a transfer.
- Mode/sel changes take effect on the same cycle's grant. The beat already in the output register is unaffected.
- A producer must hold in_valid/in_data until accepted. The block does not check this.

Optional Feature:
- Macro: MUX_LOCK_EN.
- Defined:
  - Accepting a beat with in_last[gnt]=0 sets lock=1 and lock_ch=gnt.
  - While locked, gnt=lock_ch and gnt_vld=in_valid[lock_ch], regardless of mode and sel.
  - Accepting a beat with in_last=1 from lock_ch clears the lock.
  - rr_ptr updates only when a beat with in_last=1 is accepted.
  - Single-beat packets (in_last=1 on the first beat) never lock.
- Not defined: in_last is ignored, every beat is arbitrated independently, and there is no lock state.

Decomposition:
- Package mux_pkg:
  - Constants MODE_SEL=1'b0 and MODE_RR=1'b1.
  - Function clog2 used to derive SW.
- Sub-module rr_arbiter: combinational, parameter N, inputs req[N] and ptr[SW], outputs gnt[SW] and gnt_vld. Instantiated once.
- Handshake, output register, pointer and lock logic remain in the top module.

Test Plan:
- Reset: assert rst mid-stream with out_valid=1 → out_valid=0, out_data=0, out_sel=0 asynchronously; after release, rr_ptr=0, so with in_valid=4'b1111 the first grant is channel 0.
- Select mode, N=4, W=8: sel=2, in_data[2]=8'hA5, in_valid=4'b0100, out_ready=1 → in_ready=4'b0100; next cycle out_valid=1, out_data=8'hA5, out_sel=2. Then set sel=1 with in_valid[1]=0 → in_ready=0 and out_valid drops.
- Round-robin fairness: in_valid=4'b1111 held, out_ready=1 → out_sel sequence 0,1,2,3,0,… at one beat per cycle. With in_valid=4'b1010 → sequence 1,3,1,3.
- Backpressure: out_ready=0 for 3 cycles with all channels valid → out_data/out_sel stable, in_ready=0 throughout; release → next grant continues from the stored rr_ptr with no beat lost or duplicated.
- Wrap and edge cases: N=3, select mode with sel=3 → no grant. Round-robin with only channel 2 valid → rr_ptr wraps to 0 after each grant.
- MUX_LOCK_EN: round-robin mode, channel 1 sends 3 beats (in_last=0,0,1) while channel 2 is also valid → out_sel=1,1,1, then 2; toggling mode/sel during the packet has no effect.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared constants and helpers for the N-input arbitrated multiplexer.
package mux_pkg;

  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_RR  = 1'b1;

  // Index width for n channels, never below 1 bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/mux_nin_1out_arb_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, wrapping at N.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int N = 4,
  localparam int SW = clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic [SW-1:0] gnt,
  output logic          gnt_vld
);

  logic [N-1:0] w_rot;

  // Bit k of the rotated vector is req[(ptr + k) mod N].
  assign w_rot = N'({req, req} >> ptr);

  always_comb begin
    gnt     = '0;
    gnt_vld = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        gnt_vld = 1'b1;
        gnt     = SW'((int'(ptr) + k >= N) ? (int'(ptr) + k - N) : (int'(ptr) + k));
      end
    end
  end

endmodule

// File: rtl/mux_nin_1out_arb.sv
// N-input W-bit mux with valid/ready per channel, select or round-robin mode, registered output.
// Optional packet lock (in_last honoured) is enabled by defining MUX_LOCK_EN.
module mux_nin_1out_arb
  import mux_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 8,
  localparam int SW = clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mode,
  input  logic [SW-1:0]   sel,
  input  logic [N-1:0]    in_valid,
  input  logic [N*W-1:0]  in_data,
  input  logic [N-1:0]    in_last,
  output logic [N-1:0]    in_ready,
  output logic            out_valid,
  output logic [W-1:0]    out_data,
  output logic [SW-1:0]   out_sel,
  input  logic            out_ready
);

  logic            r_out_valid;
  logic [W-1:0]    r_out_data;
  logic [SW-1:0]   r_out_sel;
  logic [SW-1:0]   r_rr_ptr;

  logic            w_load_en;
  logic            w_sel_vld;
  logic            w_rr_vld;
  logic            w_gnt_vld;
  logic            w_xfer;
  logic            w_rr_upd;
  logic [SW-1:0]   w_rr_gnt;
  logic [SW-1:0]   w_gnt;
  logic [SW-1:0]   w_next_ptr;
  logic [W-1:0]    w_gnt_data;

  // Handshake: in_ready[i] is only raised for the granted channel when the
  // output register is empty or being drained; a beat moves when valid & ready.
  assign w_load_en = ~r_out_valid | out_ready;
  assign w_xfer    = w_load_en & w_gnt_vld;

  rr_arbiter #(.N(N)) u_rr_arbiter (
    .req     (in_valid),
    .ptr     (r_rr_ptr),
    .gnt     (w_rr_gnt),
    .gnt_vld (w_rr_vld)
  );

  // sel values at or above N match no channel and therefore grant nothing.
  always_comb begin
    w_sel_vld = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (sel == SW'(i)) w_sel_vld = in_valid[i];
    end
  end

`ifdef MUX_LOCK_EN
  logic          r_lock;
  logic [SW-1:0] r_lock_ch;
  logic          w_lock_vld;
  logic          w_gnt_last;

  always_comb begin
    w_lock_vld = 1'b0;
    w_gnt_last = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (r_lock_ch == SW'(i)) w_lock_vld = in_valid[i];
      if (w_gnt == SW'(i))     w_gnt_last = in_last[i];
    end
  end

  always_comb begin
    if (r_lock) begin
      w_gnt     = r_lock_ch;
      w_gnt_vld = w_lock_vld;
    end else if (mode == MODE_RR) begin
      w_gnt     = w_rr_gnt;
      w_gnt_vld = w_rr_vld;
    end else begin
      w_gnt     = sel;
      w_gnt_vld = w_sel_vld;
    end
  end

  // The pointer advances once per packet, when its final beat is taken.
  assign w_rr_upd = w_xfer & w_gnt_last & ((mode == MODE_RR) | r_lock);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lock    <= 1'b0;
      r_lock_ch <= '0;
    end else if (w_xfer) begin
      r_lock    <= ~w_gnt_last;
      r_lock_ch <= w_gnt;
    end
  end
`else
  logic w_unused_last;
  assign w_unused_last = ^in_last;

  always_comb begin
    if (mode == MODE_RR) begin
      w_gnt     = w_rr_gnt;
      w_gnt_vld = w_rr_vld;
    end else begin
      w_gnt     = sel;
      w_gnt_vld = w_sel_vld;
    end
  end

  assign w_rr_upd = w_xfer & (mode == MODE_RR);
`endif

  always_comb begin
    in_ready   = '0;
    w_gnt_data = '0;
    for (int i = 0; i < N; i++) begin
      in_ready[i] = w_xfer && (w_gnt == SW'(i));
      if (w_gnt == SW'(i)) w_gnt_data = in_data[i*W +: W];
    end
  end

  assign w_next_ptr = (w_gnt == SW'(N - 1)) ? '0 : (w_gnt + SW'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sel   <= '0;
      r_rr_ptr    <= '0;
    end else begin
      if (w_xfer) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_gnt_data;
        r_out_sel   <= w_gnt;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (w_rr_upd) r_rr_ptr <= w_next_ptr;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sel   = r_out_sel;

endmodule

// File: tb/tb_mux_nin_1out_arb.sv
// Self-checking bench for mux_nin_1out_arb: N=4 scoreboard run plus an N=3 edge-case instance.
module tb_mux_nin_1out_arb;
  import mux_pkg::*;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int SW = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- N=4 DUT ----------------
  logic            mode;
  logic [SW-1:0]   sel;
  logic [N-1:0]    in_valid;
  logic [N*W-1:0]  in_data;
  logic [N-1:0]    in_last;
  logic [N-1:0]    in_ready;
  logic            out_valid;
  logic [W-1:0]    out_data;
  logic [SW-1:0]   out_sel;
  logic            out_ready;

  mux_nin_1out_arb #(.N(N), .W(W)) u_dut (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_sel(out_sel), .out_ready(out_ready)
  );

  // ---------------- N=3 DUT ----------------
  logic         mode3;
  logic [1:0]   sel3;
  logic [2:0]   in_valid3;
  logic [23:0]  in_data3;
  logic [2:0]   in_last3;
  logic [2:0]   in_ready3;
  logic         out_valid3;
  logic [7:0]   out_data3;
  logic [1:0]   out_sel3;
  logic         out_ready3;

  mux_nin_1out_arb #(.N(3), .W(8)) u_dut3 (
    .clk(clk), .rst(rst), .mode(mode3), .sel(sel3),
    .in_valid(in_valid3), .in_data(in_data3), .in_last(in_last3), .in_ready(in_ready3),
    .out_valid(out_valid3), .out_data(out_data3), .out_sel(out_sel3), .out_ready(out_ready3)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [SW+W-1:0] exp_q[$];
  logic [SW-1:0]   obs_sel[$];
  logic            m_out_valid;
  logic [SW-1:0]   m_ptr;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_grant(input logic md, input logic [SW-1:0] s, input logic [N-1:0] v,
                         output logic [SW-1:0] g, output logic gv);
    g  = '0;
    gv = 1'b0;
    if (md == MODE_RR) begin
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (int'(m_ptr) + k) % N;
        if (!gv && v[idx]) begin
          g  = SW'(idx);
          gv = 1'b1;
        end
      end
    end else begin
      g  = s;
      gv = v[s];
    end
  endtask

  // Called at a falling edge: drive, check against model, advance model, wait one cycle.
  task automatic drive_cycle(input logic md, input logic [SW-1:0] s, input logic [N-1:0] v,
                             input logic [31:0] d, input logic rdy);
    logic [SW-1:0] g;
    logic          gv;
    logic          ld;
    mode = md; sel = s; in_valid = v; in_data = d; out_ready = rdy;
    #1;
    m_grant(md, s, v, g, gv);
    ld = !m_out_valid || rdy;
    check_eq("in_ready", 32'(in_ready), (ld && gv) ? (32'd1 << g) : 32'd0);
    check_eq("out_valid", 32'(out_valid), 32'(m_out_valid));
    if (m_out_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL out_beat: got %0h expected none (queue empty)", {out_sel, out_data});
      end else begin
        check_eq("out_beat", 32'({out_sel, out_data}), 32'(exp_q[0]));
        if (rdy) begin
          obs_sel.push_back(out_sel);
          void'(exp_q.pop_front());
        end
      end
    end
    if (ld && gv) begin
      exp_q.push_back({g, d[g*W +: W]});
      m_out_valid = 1'b1;
      if (md == MODE_RR) m_ptr = SW'((int'(g) + 1) % N);
    end else if (rdy) begin
      m_out_valid = 1'b0;
    end
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  logic [SW-1:0] exp_seq [8];
  logic [31:0]   bp_data;

  initial begin
    rst = 1'b1;
    mode = MODE_SEL; sel = '0; in_valid = '0; in_data = '0; in_last = '1; out_ready = 1'b0;
    mode3 = MODE_SEL; sel3 = '0; in_valid3 = '0; in_data3 = '0; in_last3 = '1; out_ready3 = 1'b1;
    m_out_valid = 1'b0;
    m_ptr = '0;
    repeat (2) @(negedge clk);

    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_data", 32'(out_data), 32'd0);
    check_eq("rst_out_sel", 32'(out_sel), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // select mode directed
    drive_cycle(MODE_SEL, 2'd2, 4'b0100, 32'h00A5_0000, 1'b1);
    check_eq("sel_out_valid", 32'(out_valid), 32'd1);
    check_eq("sel_out_data", 32'(out_data), 32'hA5);
    check_eq("sel_out_sel", 32'(out_sel), 32'd2);
    drive_cycle(MODE_SEL, 2'd1, 4'b0100, 32'h00A5_0000, 1'b1);
    check_eq("sel_idle_in_ready", 32'(in_ready), 32'd0);
    check_eq("sel_idle_out_valid", 32'(out_valid), 32'd0);

    // round-robin fairness
    obs_sel.delete();
    repeat (4) drive_cycle(MODE_RR, 2'($urandom_range(0, 3)), 4'b1111, $urandom, 1'b1);
    repeat (4) drive_cycle(MODE_RR, 2'($urandom_range(0, 3)), 4'b1010, $urandom, 1'b1);
    drive_cycle(MODE_RR, 2'd0, 4'b0000, 32'd0, 1'b1);
    exp_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1, 2'd3, 2'd1, 2'd3};
    check_eq("rr_seq_len", 32'(obs_sel.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < obs_sel.size()) check_eq($sformatf("rr_seq[%0d]", i), 32'(obs_sel[i]), 32'(exp_seq[i]));
    end

    // backpressure
    bp_data = 32'hD4C3_B2A1;
    drive_cycle(MODE_RR, 2'd0, 4'b1111, bp_data, 1'b1);
    repeat (3) drive_cycle(MODE_RR, 2'd0, 4'b1111, bp_data, 1'b0);
    repeat (5) drive_cycle(MODE_RR, 2'd0, 4'b1111, bp_data, 1'b1);

    // random mix
    repeat (300) drive_cycle(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                             4'($urandom_range(0, 15)), $urandom, $urandom_range(0, 3) != 0);

    // asynchronous reset while a beat is held
    drive_cycle(MODE_RR, 2'd0, 4'b1111, bp_data, 1'b0);
    #2 rst = 1'b1;
    #1;
    check_eq("arst_out_valid", 32'(out_valid), 32'd0);
    check_eq("arst_out_data", 32'(out_data), 32'd0);
    check_eq("arst_out_sel", 32'(out_sel), 32'd0);
    exp_q.delete();
    m_out_valid = 1'b0;
    m_ptr = '0;
    @(negedge clk);
    rst = 1'b0;
    mode = MODE_RR; in_valid = 4'b1111; out_ready = 1'b1;
    #1;
    check_eq("arst_first_gnt", 32'(in_ready), 32'b0001);
    @(negedge clk);
    // the model still sees the register as empty; replay the same grant through it
    exp_q.push_back({2'd0, bp_data[7:0]});
    m_out_valid = 1'b1;
    m_ptr = 2'd1;
    repeat (4) drive_cycle(MODE_RR, 2'd0, 4'b1111, bp_data, 1'b1);

    // N=3 edge cases
    mode3 = MODE_SEL; sel3 = 2'd3; in_valid3 = 3'b111;
    #1;
    check_eq("n3_sel3_in_ready", 32'(in_ready3), 32'd0);
    @(negedge clk);
    check_eq("n3_sel3_out_valid", 32'(out_valid3), 32'd0);
    mode3 = MODE_RR; in_valid3 = 3'b100;
    for (int i = 0; i < 2; i++) begin
      in_data3 = {8'(8'h30 + i), 16'h0000};
      #1;
      check_eq("n3_rr_in_ready", 32'(in_ready3), 32'b100);
      @(negedge clk);
      check_eq("n3_rr_out_sel", 32'(out_sel3), 32'd2);
      check_eq("n3_rr_out_data", 32'(out_data3), 32'(8'h30 + i));
    end
    in_valid3 = 3'b011;
    #1;
    check_eq("n3_rr_wrap", 32'(in_ready3), 32'b001);
    @(negedge clk);

`ifdef MUX_LOCK_EN
    begin
      logic         lk_mode [5];
      logic [1:0]   lk_sel  [5];
      logic [3:0]   lk_last [5];
      logic [3:0]   lk_rdy  [5];
      logic [1:0]   lk_osel [5];
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      lk_mode = '{MODE_RR, MODE_SEL, MODE_SEL, MODE_RR, MODE_RR};
      lk_sel  = '{2'd0, 2'd2, 2'd3, 2'd0, 2'd0};
      lk_last = '{4'b1101, 4'b1101, 4'b1111, 4'b1111, 4'b1111};
      lk_rdy  = '{4'b0010, 4'b0010, 4'b0010, 4'b0100, 4'b0010};
      lk_osel = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd1};
      in_valid = 4'b0110; out_ready = 1'b1; in_data = '0;
      for (int i = 0; i < 5; i++) begin
        mode = lk_mode[i]; sel = lk_sel[i]; in_last = lk_last[i];
        #1;
        check_eq($sformatf("lock_in_ready[%0d]", i), 32'(in_ready), 32'(lk_rdy[i]));
        @(negedge clk);
        check_eq($sformatf("lock_out_sel[%0d]", i), 32'(out_sel), 32'(lk_osel[i]));
      end
      in_last = '1;
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
